// File: rtl/mem_bus_if.sv
// Processor-side request/response bus between proc2 and mem_bus_ctrl.
// The master drives the request fields and the slave returns read data and a Ready pulse.
interface mem_bus_if;
   logic        Req;
   logic        W;
   logic [15:0] ADDR;
   logic [15:0] DOUT;
   logic [15:0] DIN;
   logic        Ready;

   modport master (output Req, W, ADDR, DOUT, input DIN, Ready);
   modport slave  (input Req, W, ADDR, DOUT, output DIN, Ready);
endinterface

// File: rtl/mem_bus_ctrl.sv
// Memory-side bus controller: decodes proc2 requests into RAM, ROM, LED and switch regions.
// Optional macro BUS_ACCESS_COUNT_EN adds a readable access counter at region 4.
module mem_bus_ctrl #(
   parameter int RAM_AW      = 8,
   parameter int ROM_AW      = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic              Clock,
   input  logic              Reset,
   mem_bus_if.slave          bus,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [15:0]       rom_q,
   input  logic [9:0]        SW,
   output logic [9:0]        LEDR,
   output logic              Fault,
   output logic [15:0]       Fault_addr
);

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_WAIT, ST_RESP} state_t;

   localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        latch;
   logic [15:0] addr_q, wdata_q, din_q;
   logic        w_q;
   logic [9:0]  led_q, sw_meta_q, sw_sync_q;
   logic        fault_q;
   logic [15:0] fault_addr_q;
   logic [15:0] ram_q;
   logic [15:0] mem [2**RAM_AW];
   logic [3:0]  region;
   logic        is_mem, is_mapped, wr_forbidden, acc_fault, commit, ram_we;
   logic [15:0] rd_data;
   logic        unused_addr_bits;
`ifdef BUS_ACCESS_COUNT_EN
   logic [15:0] acc_cnt_q;
`endif

   assign region           = addr_q[15:12];
   assign is_mem           = (region == 4'd0) || (region == 4'd1);
   assign commit           = (state_q == ST_RESP);
   assign unused_addr_bits = ^addr_q;

`ifdef BUS_ACCESS_COUNT_EN
   assign is_mapped    = (region <= 4'd4);
   assign wr_forbidden = (region == 4'd0) || (region == 4'd4);
`else
   assign is_mapped    = (region <= 4'd3);
   assign wr_forbidden = (region == 4'd0);
`endif
   assign acc_fault = !is_mapped || (w_q && wr_forbidden);

   always_comb begin
      rd_data = 16'h0000;
      case (region)
         4'd0: rd_data = rom_q;
         4'd1: rd_data = ram_q;
         4'd2: rd_data = {6'b0, led_q};
         4'd3: rd_data = {6'b0, sw_sync_q};
`ifdef BUS_ACCESS_COUNT_EN
         4'd4: rd_data = acc_cnt_q;
`endif
         default: rd_data = 16'h0000;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      latch   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.Req) begin
               latch   = 1'b1;
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (is_mem && (WAIT_STATES > 0)) begin
               cnt_d   = WS_LOAD;
               state_d = ST_WAIT;
            end else begin
               state_d = ST_RESP;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) state_d = ST_RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         addr_q       <= 16'h0000;
         w_q          <= 1'b0;
         wdata_q      <= 16'h0000;
         din_q        <= 16'h0000;
         led_q        <= 10'h000;
         sw_meta_q    <= 10'h000;
         sw_sync_q    <= 10'h000;
         fault_q      <= 1'b0;
         fault_addr_q <= 16'h0000;
`ifdef BUS_ACCESS_COUNT_EN
         acc_cnt_q    <= 16'h0000;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sw_meta_q <= SW;
         sw_sync_q <= sw_meta_q;
         if (latch) begin
            addr_q  <= bus.ADDR;
            w_q     <= bus.W;
            wdata_q <= bus.DOUT;
         end
         // Everything an access changes takes effect on the edge that leaves RESP.
         if (commit) begin
            if (!w_q) din_q <= rd_data;
            if (w_q && (region == 4'd2)) led_q <= wdata_q[9:0];
            if (acc_fault) begin
               fault_q <= 1'b1;
               if (!fault_q) fault_addr_q <= addr_q;
            end
`ifdef BUS_ACCESS_COUNT_EN
            acc_cnt_q <= acc_cnt_q + 16'd1;
`endif
         end
      end
   end

   // RAM array is not reset; Reset gates the write so an aborted transaction never commits.
   assign ram_we = commit && w_q && (region == 4'd1) && !Reset;

   always_ff @(posedge Clock) begin
      if (ram_we) mem[addr_q[RAM_AW-1:0]] <= wdata_q;
      ram_q <= mem[addr_q[RAM_AW-1:0]];
   end

   assign rom_addr   = addr_q[ROM_AW-1:0];
   assign bus.DIN    = (commit && !w_q) ? rd_data : din_q;
   assign bus.Ready  = commit;
   assign LEDR       = led_q;
   assign Fault      = fault_q;
   assign Fault_addr = fault_addr_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Randomized self-checking bench for mem_bus_ctrl against a transaction-level reference model.
module tb_mem_bus_ctrl;
  localparam int WS = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rom_addr;
  logic [15:0] rom_q;
  logic [9:0]  sw, ledr;
  logic        fault;
  logic [15:0] fault_addr;

  mem_bus_if bus();

  mem_bus_ctrl #(.RAM_AW(8), .ROM_AW(8), .WAIT_STATES(WS)) dut (
    .Clock(clk), .Reset(rst), .bus(bus), .rom_addr(rom_addr), .rom_q(rom_q),
    .SW(sw), .LEDR(ledr), .Fault(fault), .Fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  // external synchronous ROM with one-cycle registered read
  logic [15:0] rom_mem [256];
  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  // reference model state
  logic [15:0] m_ram [256];
  logic [9:0]  m_led;
  logic        m_fault;
  logic [15:0] m_faddr, m_din, m_cnt;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_mapped(input logic [3:0] r);
`ifdef BUS_ACCESS_COUNT_EN
    return r <= 4'd4;
`else
    return r <= 4'd3;
`endif
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] a);
    case (a[15:12])
      4'd0: return rom_mem[a[7:0]];
      4'd1: return m_ram[a[7:0]];
      4'd2: return {6'b0, m_led};
      4'd3: return {6'b0, sw};
      4'd4: return model_mapped(4'd4) ? m_cnt : 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    m_led = '0; m_fault = 1'b0; m_faddr = '0; m_din = '0; m_cnt = '0;
  endtask

  task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d, input bit hold);
    logic [3:0]  r;
    logic [15:0] exp_rd;
    bit          flt;
    int          n, exp_n;
    r      = a[15:12];
    exp_rd = model_read(a);
    flt    = !model_mapped(r) || (w && (r == 4'd0 || r == 4'd4));
    exp_n  = 2 + ((r < 4'd2) ? WS : 0);
    @(negedge clk);
    bus.Req = 1'b1; bus.W = w; bus.ADDR = a; bus.DOUT = d;
    @(posedge clk);
    #1;
    if (!hold) bus.Req = 1'b0;
    bus.W = ~w; bus.ADDR = 16'($urandom); bus.DOUT = 16'($urandom);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (n == 1 && r == 4'd0) chk("rom_addr", rom_addr, a[7:0]);
      if (bus.Ready === 1'b1 || n > 40) break;
    end
    chk("latency", n, exp_n);
    if (!w) chk("din_resp", bus.DIN, exp_rd);
    bus.Req = 1'b0;
    if (!w) m_din = exp_rd;
    if (w && r == 4'd1) m_ram[a[7:0]] = d;
    if (w && r == 4'd2) m_led = d[9:0];
    if (flt) begin
      if (!m_fault) m_faddr = a;
      m_fault = 1'b1;
    end
    m_cnt = m_cnt + 16'd1;
    @(negedge clk);
    chk("ready_pulse", bus.Ready, 1'b0);
    chk("din_hold", bus.DIN, m_din);
    chk("ledr", ledr, m_led);
    chk("fault", fault, m_fault);
    chk("fault_addr", fault_addr, m_faddr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  r;
    logic [15:0] a;
    for (int i = 0; i < 256; i++) rom_mem[i] = 16'($urandom);
    rom_mem[3] = 16'h1234;
    rst = 1'b1; bus.Req = 1'b0; bus.W = 1'b0; bus.ADDR = '0; bus.DOUT = '0; sw = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus.Ready, 1'b0);
    chk("rst_din", bus.DIN, 16'h0000);
    chk("rst_ledr", ledr, 10'h000);
    chk("rst_fault", fault, 1'b0);
    chk("rst_faddr", fault_addr, 16'h0000);
    chk("rst_rom_addr", rom_addr, 8'h00);

    for (int i = 0; i < 16; i++) access(1'b1, 16'h1000 | 16'(i), 16'($urandom), 1'b0);

    access(1'b1, 16'h1005, 16'h00AB, 1'b0);
    access(1'b0, 16'h1005, 16'h0000, 1'b0);
    chk("ram_rd_0x1005", bus.DIN, 16'h00AB);
    access(1'b0, 16'h0003, 16'h0000, 1'b0);
    chk("rom_rd_3", bus.DIN, 16'h1234);
    access(1'b1, 16'h2000, 16'hFFFF, 1'b0);
    chk("led_all", ledr, 10'h3FF);
    sw = 10'h155;
    repeat (3) @(negedge clk);
    access(1'b0, 16'h3000, 16'h0000, 1'b0);
    chk("sw_rd", bus.DIN, 16'h0155);
    access(1'b1, 16'h0010, 16'h5555, 1'b0);
    access(1'b0, 16'h7000, 16'h0000, 1'b0);
    chk("unmapped_rd", bus.DIN, 16'h0000);
    chk("first_fault_addr", fault_addr, 16'h0010);
    access(1'b0, 16'h1103, 16'h0000, 1'b1);

    // RAM write aborted by reset during WAIT
    @(negedge clk);
    bus.Req = 1'b1; bus.W = 1'b1; bus.ADDR = 16'h1003; bus.DOUT = ~m_ram[3];
    @(posedge clk);
    #1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.Req = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_no_ready", bus.Ready, 1'b0);
    end
    chk("abort_din", bus.DIN, 16'h0000);
    chk("abort_fault", fault, 1'b0);
    access(1'b0, 16'h1003, 16'h0000, 1'b0);
    access(1'b1, 16'h2000, 16'h0077, 1'b0);
    access(1'b0, 16'h0003, 16'h0000, 1'b0);
    access(1'b0, 16'h4000, 16'h0000, 1'b0);
`ifdef BUS_ACCESS_COUNT_EN
    chk("cnt_rd", bus.DIN, 16'h0003);
    chk("cnt_rd_nofault", fault, 1'b0);
`else
    chk("region4_rd", bus.DIN, 16'h0000);
    chk("region4_fault", fault, 1'b1);
`endif

    for (int t = 0; t < 200; t++) begin
      case ($urandom_range(0, 7))
        0:       r = 4'd0;
        1, 2:    r = 4'd1;
        3:       r = 4'd2;
        4:       r = 4'd3;
        5:       r = 4'd4;
        6:       r = 4'($urandom_range(5, 15));
        default: r = 4'd1;
      endcase
      a = {r, 12'($urandom)};
      if (r == 4'd1) a[7:4] = 4'h0;
      if ($urandom_range(0, 3) == 0) sw = 10'($urandom);
      access(1'($urandom), a, 16'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
